digital_clock: RTL and testbench
================================

DIGITAL_CLOCK -- requirements
Module: digital_clock

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000; input clock cycles per one-second tick.
REQ-002 Parameter SCAN_DIV, default 50_000; clock cycles per display digit slot (1 kHz digit rate at 50 MHz).
REQ-003 clk  input  1  single system clock, rising-edge active, 50 MHz nominal.
REQ-004 rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 seg_out  output  7  segment drive, active-low (0 = lit); bit0=a … bit6=g.
REQ-006 digit_sel  output  6  digit enable, active-low one-hot; bit0 = seconds-ones … bit5 = hours-tens.

Function
REQ-007 Timekeeping SHALL be 24-hour HH:MM:SS in BCD: six digit registers, seconds-ones through hours-tens.
REQ-008 Prescaler SHALL count 0..CLK_FREQ_HZ-1 and wrap. It SHALL issue a one-cycle tick on the wrap cycle.
REQ-009 On each tick, seconds SHALL increment. 59 s wraps to 00 and carries to minutes; 59 min wraps to 00 and carries to hours; 23:59:59 wraps to 00:00:00 in one tick.
REQ-010 Ones digits SHALL wrap 9->0 with carry. Seconds/minutes tens SHALL wrap 5->0. Hours SHALL wrap 23->00, with no illegal BCD value ever reachable.
REQ-011 Scan counter SHALL count 0..SCAN_DIV-1 and wrap. On wrap, digit index SHALL advance 0,1,2,3,4,5,0…
REQ-012 digit_sel SHALL assert exactly one bit low, index = digit index. seg_out SHALL show the decoded value of that digit.
REQ-013 digit_sel and seg_out SHALL be registered, with one cycle latency from digit index/BCD change to pins.
REQ-014 Decode (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other input SHALL give 1111111.
REQ-015 A tick and a scan advance in the same cycle SHALL both take effect. The displayed value SHALL be the post-tick value from the next output register update.

Reset
REQ-016 While rst=0: all time digits 0, prescaler 0, scan counter 0, digit index 0, digit_sel=111111 (blank), seg_out=1111111.
REQ-017 Reset assertion SHALL take effect immediately and asynchronously, mid-count or mid-scan.
REQ-018 Release is synchronous. On the first rising edge after rst=1, outputs SHALL become digit_sel=111110 and seg_out=1000000 (seconds-ones "0").

Configuration
REQ-019 Macro FAST_SIM_EN:
- Defined: tick period 1000 cycles (20 us at 50 MHz) and scan period 8 cycles, overriding CLK_FREQ_HZ/SCAN_DIV.
- Undefined: parameters are used unchanged.
- No other behaviour differs.

Structure
REQ-020 Package digital_clock_pkg SHALL hold:
- the 7-segment pattern constants and the blank constant;
- NUM_DIGITS=6;
- BCD digit typedef (4 bits).
REQ-021 Sub-module seg7_decoder SHALL be combinational: 4-bit BCD in, 7-bit active-low pattern out. Instantiate it once, after the digit mux.
REQ-022 Prescaler, BCD time counter chain and scan/mux logic SHALL live in digital_clock.

Verification
REQ-023 rst=0 for 100 ns then released -> during reset digit_sel=111111 and seg_out=1111111; first edge after release gives digit_sel=111110 and seg_out=1000000.
REQ-024 FAST_SIM_EN, run 65 us after release -> digit_sel cycles 111110,111101,…,011111 every 8 cycles; seconds-ones reads 1 after 20 us, 2 after 40 us, 3 after 60 us; other digits stay 1000000.
REQ-025 Force time 00:00:59 then one tick -> 00:01:00; 00:59:59 -> 01:00:00; 09:59:59 -> 10:00:00.
REQ-026 Force time 23:59:59 then one tick -> 00:00:00, and all six digits display 1000000.
REQ-027 Assert rst mid-scan at digit index 3 with time 12:34:56 -> outputs blank immediately; after release, time 00:00:00 and index 0.
REQ-028 Check the decoder exhaustively over inputs 0..15 -> matches REQ-014, with 10..15 giving 1111111.

Source files
------------

// File: rtl/digital_clock_pkg.sv
// Shared constants and types for the 24-hour BCD digital clock.
// Build option: FAST_SIM_EN (see digital_clock.sv).
package digital_clock_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [3:0] bcd_t;
    typedef logic [2:0] digit_idx_t;

    // Active-low 7-segment patterns, bit order g..a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [5:0] DIG_BLANK = 6'b111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes blank.
module seg7_decoder
    import digital_clock_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    // Pattern lookup
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digital_clock.sv
// 24-hour HH:MM:SS clock with multiplexed six-digit 7-segment display.
// Build option FAST_SIM_EN: 1000-cycle tick and 8-cycle scan slot.
module digital_clock
    import digital_clock_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SCAN_DIV    = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] seg_out,
    output logic [5:0] digit_sel
);

`ifdef FAST_SIM_EN
    localparam int TICK_P = 1000;
    localparam int SCAN_P = 8;
`else
    localparam int TICK_P = CLK_FREQ_HZ;
    localparam int SCAN_P = SCAN_DIV;
`endif
    localparam int PW = (TICK_P > 1) ? $clog2(TICK_P) : 1;
    localparam int SW = (SCAN_P > 1) ? $clog2(SCAN_P) : 1;

    logic [PW-1:0]             presc_q, presc_d;
    logic [SW-1:0]             scan_q, scan_d;
    digit_idx_t                idx_q, idx_d;
    bcd_t [NUM_DIGITS-1:0]     time_q, time_d;
    logic [6:0]                seg_q;
    logic [5:0]                dsel_q, dsel_d;
    logic                      tick_s, scan_wrap_s;
    bcd_t                      cur_bcd_s;
    logic [6:0]                seg_s;

    assign tick_s      = (presc_q == PW'(TICK_P - 1));
    assign scan_wrap_s = (scan_q == SW'(SCAN_P - 1));

    // Prescaler, scan counter and digit index next state
    always_comb begin
        presc_d = tick_s ? '0 : presc_q + PW'(1);
        scan_d  = scan_wrap_s ? '0 : scan_q + SW'(1);
        if (scan_wrap_s) begin
            idx_d = (idx_q >= 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            idx_d = idx_q;
        end
    end

    // BCD carry chain; >= compares steer any stray code back into range
    always_comb begin
        time_d = time_q;
        if (tick_s) begin
            if (time_q[0] >= 4'd9) begin
                time_d[0] = 4'd0;
                if (time_q[1] >= 4'd5) begin
                    time_d[1] = 4'd0;
                    if (time_q[2] >= 4'd9) begin
                        time_d[2] = 4'd0;
                        if (time_q[3] >= 4'd5) begin
                            time_d[3] = 4'd0;
                            if (time_q[5] >= 4'd2 && time_q[4] >= 4'd3) begin
                                time_d[5] = 4'd0;
                                time_d[4] = 4'd0;
                            end else if (time_q[4] >= 4'd9) begin
                                time_d[4] = 4'd0;
                                time_d[5] = time_q[5] + 4'd1;
                            end else begin
                                time_d[4] = time_q[4] + 4'd1;
                            end
                        end else begin
                            time_d[3] = time_q[3] + 4'd1;
                        end
                    end else begin
                        time_d[2] = time_q[2] + 4'd1;
                    end
                end else begin
                    time_d[1] = time_q[1] + 4'd1;
                end
            end else begin
                time_d[0] = time_q[0] + 4'd1;
            end
        end else begin
            time_d = time_q;
        end
    end

    // Digit mux and active-low one-hot select for the current slot
    always_comb begin
        cur_bcd_s = time_q[0];
        dsel_d    = DIG_BLANK;
        case (idx_q)
            3'd0:    begin cur_bcd_s = time_q[0]; dsel_d = 6'b111110; end
            3'd1:    begin cur_bcd_s = time_q[1]; dsel_d = 6'b111101; end
            3'd2:    begin cur_bcd_s = time_q[2]; dsel_d = 6'b111011; end
            3'd3:    begin cur_bcd_s = time_q[3]; dsel_d = 6'b110111; end
            3'd4:    begin cur_bcd_s = time_q[4]; dsel_d = 6'b101111; end
            3'd5:    begin cur_bcd_s = time_q[5]; dsel_d = 6'b011111; end
            default: begin cur_bcd_s = time_q[0]; dsel_d = DIG_BLANK; end
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .bcd_i (cur_bcd_s),
        .seg_o (seg_s)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            scan_q  <= '0;
            idx_q   <= 3'd0;
            time_q  <= '0;
            seg_q   <= SEG_BLANK;
            dsel_q  <= DIG_BLANK;
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            time_q  <= time_d;
            seg_q   <= seg_s;
            dsel_q  <= dsel_d;
        end
    end

    assign seg_out   = seg_q;
    assign digit_sel = dsel_q;

endmodule

// File: tb/tb_digital_clock.sv
// Directed self-checking bench for digital_clock (1000-cycle tick, 8-cycle scan).
module tb_digital_clock;
    import digital_clock_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg_out;
    logic [5:0] digit_sel;
    logic [3:0] dec_in = 4'd0;
    logic [6:0] dec_out;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ecnt     = 0;
    logic [23:0] tm       = 24'h000000;
    logic [23:0] force_val = 24'h000000;

    digital_clock #(.CLK_FREQ_HZ(1000), .SCAN_DIV(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_out   (seg_out),
        .digit_sel (digit_sel)
    );

    seg7_decoder u_dec (
        .bcd_i (dec_in),
        .seg_o (dec_out)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [23:0] ref_inc(input logic [23:0] t);
        int h, m, s, tot;
        h   = int'(t[23:20]) * 10 + int'(t[19:16]);
        m   = int'(t[15:12]) * 10 + int'(t[11:8]);
        s   = int'(t[7:4])   * 10 + int'(t[3:0]);
        tot = (h * 3600 + m * 60 + s + 1) % 86400;
        h   = tot / 3600;
        m   = (tot / 60) % 60;
        s   = tot % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int dig(input logic [23:0] t, input int i);
        logic [3:0] d;
        d = t[4*i +: 4];
        return int'(d);
    endfunction

    // One clock edge; outputs after edge e show slot ((e-1)/8)%6 of the pre-edge time
    task automatic step();
        int         idx;
        logic [5:0] exp_sel;
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        idx     = ((ecnt - 1) / 8) % 6;
        exp_sel = ~(6'b000001 << idx);
        chk("digit_sel", 32'(digit_sel), 32'(exp_sel));
        chk("seg_out", 32'(seg_out), 32'(ref_seg(dig(tm, idx))));
        if (ecnt % 1000 == 0) tm = ref_inc(tm);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task force_time(input logic [23:0] v);
        while (((ecnt + 1) % 1000 == 0) || ((ecnt + 2) % 1000 == 0)) step();
        force_val = v;
        force dut.time_q = force_val;
        tm = v;
        step();
        release dut.time_q;
    endtask

    task automatic tick_and_scan();
        while (ecnt % 1000 != 0) step();
        run(48);
    endtask

    initial begin
        #45;
        chk("rst_sel", 32'(digit_sel), 32'(6'b111111));
        chk("rst_seg", 32'(seg_out), 32'(7'b1111111));
        #40;
        chk("rst_sel2", 32'(digit_sel), 32'(6'b111111));
        chk("rst_seg2", 32'(seg_out), 32'(7'b1111111));
        #15;
        rst = 1'b1;
        run(3250);

        force_time(24'h000059); tick_and_scan();
        force_time(24'h005959); tick_and_scan();
        force_time(24'h095959); tick_and_scan();
        force_time(24'h235959); tick_and_scan();

        force_time(24'h123456);
        while (!(((ecnt / 8) % 6 == 3) && (ecnt % 8 == 3))) step();
        #3 rst = 1'b0;
        #1;
        chk("async_sel", 32'(digit_sel), 32'(6'b111111));
        chk("async_seg", 32'(seg_out), 32'(7'b1111111));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_sel", 32'(digit_sel), 32'(6'b111111));
            chk("hold_seg", 32'(seg_out), 32'(7'b1111111));
        end
        rst  = 1'b1;
        ecnt = 0;
        tm   = 24'h000000;
        run(100);

        for (int i = 0; i < 16; i++) begin
            dec_in = 4'(i);
            #1;
            chk($sformatf("dec%0d", i), 32'(dec_out), 32'(ref_seg(i)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
